// File: rtl/queue_share_pkg.sv
// Shared types and helpers for the shared-push bounded queue controller.
package queue_share_pkg;

    // Queue occupancy state; FLUSH is a one-cycle state after a flush request.
    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2,
        FLUSH  = 2'd3
    } qstate_e;

    // Pointer increment with explicit wrap at depth-1 (depth need not be a power of two).
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/queue_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last winner and wraps.
// grant is one-hot (all zero when disabled or nothing requests), index is its position.
module rr_arbiter #(
    parameter int N_REQ = 2,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic             enable,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] index
);

    logic             w_found;
    logic [IDX_W-1:0] w_cand;

    // Scan requesters in priority order last+1, last+2, ... and pick the first valid one.
    always_comb begin
        grant   = '0;
        index   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (int'(last) + k >= N_REQ) begin
                w_cand = IDX_W'(int'(last) + k - N_REQ);
            end else begin
                w_cand = IDX_W'(int'(last) + k);
            end
            if (enable && !w_found && req[w_cand]) begin
                grant[w_cand] = 1'b1;
                index         = w_cand;
                w_found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/queue_share_ctrl.sv
// Bounded FIFO controller: N_REQ producers share one push port through a
// round-robin arbiter, one consumer pops through valid/ready, plus size/full/empty
// reporting and a one-cycle flush.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both high.
// On the push side req_ready is a one-hot grant computed combinationally from
// req_valid and registered state, so a producer sees ready only while it is valid.
// On the pop side pop_valid depends on registered state only; pop_ready is ignored
// while pop_valid is low. flush overrides both ports for the cycle it is sampled.
module queue_share_ctrl
    import queue_share_pkg::*;
#(
    parameter int DEPTH  = 5,
    parameter int DATA_W = 32,
    parameter int N_REQ  = 2,
    localparam int SIZE_W = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    pop_valid,
    output logic [DATA_W-1:0]       pop_data,
    input  logic                    pop_ready,
    input  logic                    flush,
    output logic [SIZE_W-1:0]       size,
    output logic                    full,
    output logic                    empty,
    output logic [1:0]              dbg_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [SIZE_W-1:0] DEPTH_C = SIZE_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [SIZE_W-1:0] r_count;
    qstate_e           r_state;
    logic [IDX_W-1:0]  r_last_grant;

    logic [SIZE_W-1:0] w_count_nxt;
    qstate_e           w_state_nxt;
    logic [N_REQ-1:0]  w_grant;
    logic [IDX_W-1:0]  w_grant_idx;
    logic              w_pop_valid;
    logic              w_pop_fire;
    logic              w_space;
    logic              w_arb_en;
    logic              w_push_fire;
    logic [DATA_W-1:0] w_push_data;

    // A pop frees a slot in the same cycle, so a full queue can still accept a push.
    assign w_pop_valid = (r_count != '0) && (r_state != FLUSH);
    assign w_pop_fire  = w_pop_valid && pop_ready && !flush;
    assign w_space     = (r_count < DEPTH_C) || w_pop_fire;
    assign w_arb_en    = w_space && (r_state != FLUSH) && !flush;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req    (req_valid),
        .enable (w_arb_en),
        .last   (r_last_grant),
        .grant  (w_grant),
        .index  (w_grant_idx)
    );

    // The arbiter only grants valid requesters, so any grant bit is a completed push.
    assign w_push_fire = |w_grant;
    assign w_push_data = req_data[w_grant_idx*DATA_W +: DATA_W];

    // Occupancy update: simultaneous push and pop leave the count unchanged.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push_fire && !w_pop_fire) begin
            w_count_nxt = r_count + SIZE_W'(1);
        end else if (!w_push_fire && w_pop_fire) begin
            w_count_nxt = r_count - SIZE_W'(1);
        end
    end

    // Next state follows the next count; flush wins, and FLUSH always falls to EMPTY.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = FLUSH;
        end else if (r_state == FLUSH) begin
            w_state_nxt = EMPTY;
        end else if (w_count_nxt == '0) begin
            w_state_nxt = EMPTY;
        end else if (w_count_nxt == DEPTH_C) begin
            w_state_nxt = FULL;
        end else begin
            w_state_nxt = ACTIVE;
        end
    end

    // Control registers: pointers, count, state and round-robin history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_state      <= EMPTY;
            r_last_grant <= IDX_W'(N_REQ - 1);
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_state  <= FLUSH;
        end else begin
            r_count <= w_count_nxt;
            r_state <= w_state_nxt;
            if (w_push_fire) begin
                r_wr_ptr     <= PTR_W'(next_ptr(32'(r_wr_ptr), DEPTH));
                r_last_grant <= w_grant_idx;
            end
            if (w_pop_fire) begin
                r_rd_ptr <= PTR_W'(next_ptr(32'(r_rd_ptr), DEPTH));
            end
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (w_push_fire) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    assign req_ready = w_grant;
    assign pop_valid = w_pop_valid;
    assign pop_data  = r_mem[r_rd_ptr];
    assign size      = r_count;
    assign full      = (r_count == DEPTH_C);
    assign empty     = (r_count == '0);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_queue_share_ctrl.sv
// Bench for queue_share_ctrl: table of per-cycle vectors with hand-derived
// expectations, a FIFO scoreboard for popped data, and a hand-written reset sequence.
module tb_queue_share_ctrl;
    import queue_share_pkg::*;

    localparam int DEPTH  = 5;
    localparam int DATA_W = 32;
    localparam int N_REQ  = 2;
    localparam int SIZE_W = $clog2(DEPTH + 1);

    logic                    clk;
    logic                    rst_n;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    pop_valid;
    logic [DATA_W-1:0]       pop_data;
    logic                    pop_ready;
    logic                    flush;
    logic [SIZE_W-1:0]       size;
    logic                    full;
    logic                    empty;
    logic [1:0]              dbg_state;

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        pop;
        logic        fl;
        logic [1:0]  exp_ready;
        int          exp_size;
        logic        exp_pv;
        qstate_e     exp_state;
    } vec_t;

    vec_t              vecs[$];
    logic [DATA_W-1:0] exp_q[$];
    int                n_checks;
    int                n_err;

    queue_share_ctrl #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .N_REQ  (N_REQ)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .pop_valid (pop_valid),
        .pop_data  (pop_data),
        .pop_ready (pop_ready),
        .flush     (flush),
        .size      (size),
        .full      (full),
        .empty     (empty),
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [1:0] valid, input logic [31:0] d0, input logic [31:0] d1,
                                input logic pop, input logic fl, input logic [1:0] exp_ready,
                                input int exp_size, input logic exp_pv, input qstate_e exp_state);
        vec_t v;
        v.valid = valid; v.d0 = d0; v.d1 = d1; v.pop = pop; v.fl = fl;
        v.exp_ready = exp_ready; v.exp_size = exp_size; v.exp_pv = exp_pv; v.exp_state = exp_state;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle at the falling edge, check just after, then update the scoreboard.
    task automatic step(input int tag, input vec_t v);
        @(negedge clk);
        req_valid = v.valid;
        req_data  = {v.d1, v.d0};
        pop_ready = v.pop;
        flush     = v.fl;
        #1;
        check($sformatf("v%0d.req_ready", tag), 32'(req_ready), 32'(v.exp_ready));
        check($sformatf("v%0d.size", tag), 32'(size), v.exp_size);
        check($sformatf("v%0d.full", tag), 32'(full), 32'(v.exp_size == DEPTH));
        check($sformatf("v%0d.empty", tag), 32'(empty), 32'(v.exp_size == 0));
        check($sformatf("v%0d.pop_valid", tag), 32'(pop_valid), 32'(v.exp_pv));
        check($sformatf("v%0d.state", tag), 32'(dbg_state), 32'(v.exp_state));
        if (v.exp_pv && v.pop && !v.fl) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL v%0d.pop_data: got %0h expected nothing queued", tag, pop_data);
            end else begin
                check($sformatf("v%0d.pop_data", tag), pop_data, exp_q.pop_front());
            end
        end
        if (v.exp_ready[0] && v.valid[0]) exp_q.push_back(v.d0);
        if (v.exp_ready[1] && v.valid[1]) exp_q.push_back(v.d1);
        if (v.fl) exp_q.delete();
    endtask

    initial begin
        n_checks  = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        pop_ready = 1'b0;
        flush     = 1'b0;

        // Round-robin fill (last winner after reset is 1, so requester 0 first).
        vecs.push_back(mk(2'b11, 32'hA0, 32'hB0, 1'b0, 1'b0, 2'b01, 0, 1'b0, EMPTY));
        vecs.push_back(mk(2'b11, 32'hA1, 32'hB1, 1'b0, 1'b0, 2'b10, 1, 1'b1, ACTIVE));
        vecs.push_back(mk(2'b11, 32'hA2, 32'hB2, 1'b0, 1'b0, 2'b01, 2, 1'b1, ACTIVE));
        vecs.push_back(mk(2'b11, 32'hA3, 32'hB3, 1'b0, 1'b0, 2'b10, 3, 1'b1, ACTIVE));
        vecs.push_back(mk(2'b11, 32'hA4, 32'hB4, 1'b0, 1'b0, 2'b01, 4, 1'b1, ACTIVE));
        vecs.push_back(mk(2'b11, 32'hA5, 32'hB5, 1'b0, 1'b0, 2'b00, 5, 1'b1, FULL));
        // Full with concurrent pop: push and pop both fire, size stays 5.
        vecs.push_back(mk(2'b10, 32'h0, 32'hC0, 1'b1, 1'b0, 2'b10, 5, 1'b1, FULL));
        vecs.push_back(mk(2'b10, 32'h0, 32'hC1, 1'b1, 1'b0, 2'b10, 5, 1'b1, FULL));
        vecs.push_back(mk(2'b10, 32'h0, 32'hC2, 1'b1, 1'b0, 2'b10, 5, 1'b1, FULL));
        // Drain to empty, then pop_ready held high on an empty queue.
        vecs.push_back(mk(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 2'b00, 5, 1'b1, FULL));
        vecs.push_back(mk(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 2'b00, 4, 1'b1, ACTIVE));
        vecs.push_back(mk(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 2'b00, 3, 1'b1, ACTIVE));
        vecs.push_back(mk(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 2'b00, 2, 1'b1, ACTIVE));
        vecs.push_back(mk(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 2'b00, 1, 1'b1, ACTIVE));
        vecs.push_back(mk(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 2'b00, 0, 1'b0, EMPTY));
        vecs.push_back(mk(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 2'b00, 0, 1'b0, EMPTY));
        // Wrap-around: 7 push/pop pairs, each value popped one cycle after its push.
        vecs.push_back(mk(2'b01, 32'd1, 32'h0, 1'b1, 1'b0, 2'b01, 0, 1'b0, EMPTY));
        for (int v = 2; v <= 7; v++) begin
            vecs.push_back(mk(2'b01, 32'(v), 32'h0, 1'b1, 1'b0, 2'b01, 1, 1'b1, ACTIVE));
        end
        vecs.push_back(mk(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 2'b00, 1, 1'b1, ACTIVE));
        vecs.push_back(mk(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 0, 1'b0, EMPTY));
        // Flush at size 3 with a push and pop request in the same cycle.
        vecs.push_back(mk(2'b01, 32'h21, 32'h0, 1'b0, 1'b0, 2'b01, 0, 1'b0, EMPTY));
        vecs.push_back(mk(2'b01, 32'h22, 32'h0, 1'b0, 1'b0, 2'b01, 1, 1'b1, ACTIVE));
        vecs.push_back(mk(2'b01, 32'h23, 32'h0, 1'b0, 1'b0, 2'b01, 2, 1'b1, ACTIVE));
        vecs.push_back(mk(2'b01, 32'h24, 32'h0, 1'b1, 1'b1, 2'b00, 3, 1'b1, ACTIVE));
        vecs.push_back(mk(2'b01, 32'h24, 32'h0, 1'b1, 1'b0, 2'b00, 0, 1'b0, FLUSH));
        vecs.push_back(mk(2'b01, 32'h25, 32'h0, 1'b1, 1'b0, 2'b01, 0, 1'b0, EMPTY));
        vecs.push_back(mk(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 2'b00, 1, 1'b1, ACTIVE));
        vecs.push_back(mk(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 0, 1'b0, EMPTY));
        // Flush held for two cycles stays in FLUSH one cycle past release.
        vecs.push_back(mk(2'b01, 32'h31, 32'h0, 1'b0, 1'b0, 2'b01, 0, 1'b0, EMPTY));
        vecs.push_back(mk(2'b01, 32'h32, 32'h0, 1'b0, 1'b1, 2'b00, 1, 1'b1, ACTIVE));
        vecs.push_back(mk(2'b01, 32'h32, 32'h0, 1'b0, 1'b1, 2'b00, 0, 1'b0, FLUSH));
        vecs.push_back(mk(2'b01, 32'h32, 32'h0, 1'b0, 1'b0, 2'b00, 0, 1'b0, FLUSH));
        vecs.push_back(mk(2'b01, 32'h33, 32'h0, 1'b0, 1'b0, 2'b01, 0, 1'b0, EMPTY));
        vecs.push_back(mk(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 2'b00, 1, 1'b1, ACTIVE));
        vecs.push_back(mk(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 0, 1'b0, EMPTY));

        // Reset state while held in reset.
        #12;
        check("reset.size", 32'(size), 0);
        check("reset.empty", 32'(empty), 1);
        check("reset.full", 32'(full), 0);
        check("reset.pop_valid", 32'(pop_valid), 0);
        check("reset.req_ready", 32'(req_ready), 0);
        check("reset.state", 32'(dbg_state), 32'(EMPTY));
        @(negedge clk);
        rst_n = 1'b1;

        // Three pushes, then reset asserted mid-run wipes everything at once.
        step(-1, mk(2'b01, 32'h11, 32'h0, 1'b0, 1'b0, 2'b01, 0, 1'b0, EMPTY));
        step(-2, mk(2'b01, 32'h12, 32'h0, 1'b0, 1'b0, 2'b01, 1, 1'b1, ACTIVE));
        step(-3, mk(2'b01, 32'h13, 32'h0, 1'b0, 1'b0, 2'b01, 2, 1'b1, ACTIVE));
        @(negedge clk);
        check("pre_reset.size", 32'(size), 3);
        #2;
        rst_n     = 1'b0;
        req_valid = '0;
        pop_ready = 1'b0;
        #1;
        check("midreset.size", 32'(size), 0);
        check("midreset.empty", 32'(empty), 1);
        check("midreset.pop_valid", 32'(pop_valid), 0);
        check("midreset.state", 32'(dbg_state), 32'(EMPTY));
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(i, vecs[i]);
        end

        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
